// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell and winner codes, controller states,
// and the table of the eight winning lines.
package ttt_pkg;

  localparam int BOARD_BITS = 18;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] DRAW     = 2'b11;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_e;

  // Rows, columns, then diagonals; leftmost triple is line 0.
  localparam logic [0:7][0:2][3:0] WIN_LINES = {
    4'd0, 4'd1, 4'd2,
    4'd3, 4'd4, 4'd5,
    4'd6, 4'd7, 4'd8,
    4'd0, 4'd3, 4'd6,
    4'd1, 4'd4, 4'd7,
    4'd2, 4'd5, 4'd8,
    4'd0, 4'd4, 4'd8,
    4'd2, 4'd4, 4'd6
  };

  function automatic logic [1:0] cell_at(input logic [BOARD_BITS-1:0] b, input int idx);
    cell_at = b[2*idx +: 2];
  endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// Combinational win detector: flags any of the eight lines holding three
// identical marks and reports which player owns it.
module ttt_line_checker
  import ttt_pkg::*;
(
  input  logic [BOARD_BITS-1:0] board_i,
  output logic                  win_o,
  output logic [1:0]            player_o
);

  always_comb begin
    win_o    = 1'b0;
    player_o = EMPTY;
    for (int l = 0; l < 8; l++) begin
      if (cell_at(board_i, int'(WIN_LINES[l][0])) != EMPTY &&
          cell_at(board_i, int'(WIN_LINES[l][0])) == cell_at(board_i, int'(WIN_LINES[l][1])) &&
          cell_at(board_i, int'(WIN_LINES[l][0])) == cell_at(board_i, int'(WIN_LINES[l][2]))) begin
        win_o    = 1'b1;
        player_o = cell_at(board_i, int'(WIN_LINES[l][0]));
      end
    end
  end

endmodule

// File: rtl/ttt_move_controller.sv
// Tic-tac-toe move controller: validates placements, alternates players and
// evaluates the board one cycle after every accepted move.
module ttt_move_controller
  import ttt_pkg::*;
#(
  parameter int NUM_CELLS = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            cell_sel,
  input  logic                  place,
  input  logic                  new_game,
  output logic [BOARD_BITS-1:0] board,
  output logic                  turn,
  output logic                  move_ok,
  output logic                  move_err,
  output logic [1:0]            winner,
  output logic                  game_over
);

  state_e                state_q, state_d;
  logic [BOARD_BITS-1:0] board_q, board_d;
  logic                  turn_q, turn_d;
  logic [3:0]            count_q, count_d;
  logic [1:0]            winner_q, winner_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;

  logic                  sel_valid;
  logic                  sel_empty;
  logic                  line_win;
  logic [1:0]            line_player;

  ttt_line_checker u_line_checker (
    .board_i  (board_q),
    .win_o    (line_win),
    .player_o (line_player)
  );

  // Cursor values past the last cell come from counter wrap and never match.
  always_comb begin
    sel_valid = 1'b0;
    sel_empty = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cell_sel == 4'(i)) begin
        sel_valid = 1'b1;
        sel_empty = (board_q[2*i +: 2] == EMPTY);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    count_d  = count_q;
    winner_d = winner_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    if (new_game) begin
      state_d  = PLAY;
      board_d  = '0;
      turn_d   = 1'b0;
      count_d  = 4'd0;
      winner_d = WIN_NONE;
    end else begin
      case (state_q)
        PLAY: begin
          if (place) begin
            if (sel_valid && sel_empty) begin
              for (int i = 0; i < NUM_CELLS; i++) begin
                if (cell_sel == 4'(i)) board_d[2*i +: 2] = turn_q ? MARK_O : MARK_X;
              end
              count_d = count_q + 4'd1;
              ok_d    = 1'b1;
              state_d = CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        // A completed line outranks the full-board draw.
        CHECK: begin
          if (line_win) begin
            winner_d = line_player;
            state_d  = OVER;
          end else if (count_q == 4'(NUM_CELLS)) begin
            winner_d = DRAW;
            state_d  = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
          end
        end
        OVER: begin
          if (place) err_d = 1'b1;
        end
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PLAY;
      board_q  <= '0;
      turn_q   <= 1'b0;
      count_q  <= 4'd0;
      winner_q <= WIN_NONE;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  assign board     = board_q;
  assign turn      = turn_q;
  assign move_ok   = ok_q;
  assign move_err  = err_q;
  assign winner    = winner_q;
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_ttt_move_controller.sv
// Self-checking bench for ttt_move_controller: a game-level model is compared
// against the DUT every cycle, with literal expectations pinning key moments.
module tb_ttt_move_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cell_sel;
  logic        place;
  logic        new_game;
  logic [17:0] board;
  logic        turn;
  logic        move_ok;
  logic        move_err;
  logic [1:0]  winner;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  bit checkEnable = 1'b0;

  ttt_move_controller #(.NUM_CELLS(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .cell_sel  (cell_sel),
    .place     (place),
    .new_game  (new_game),
    .board     (board),
    .turn      (turn),
    .move_ok   (move_ok),
    .move_err  (move_err),
    .winner    (winner),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int cells [9];
  int mTurn, mCount, mWinner;
  bit mOver, mPending, mOk, mErr;

  function automatic int lineOwner();
    int owner = 0;
    for (int l = 0; l < 8; l++) begin
      if (cells[lines[l][0]] != 0 && cells[lines[l][0]] == cells[lines[l][1]] &&
          cells[lines[l][0]] == cells[lines[l][2]])
        owner = cells[lines[l][0]];
    end
    return owner;
  endfunction

  function automatic logic [17:0] packBoard();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
    return b;
  endfunction

  // Game model: a move lands on the edge it is sampled, its outcome one edge later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) cells[i] = 0;
      mTurn = 0; mCount = 0; mWinner = 0;
      mOver = 0; mPending = 0; mOk = 0; mErr = 0;
    end else begin
      mOk = 0;
      mErr = 0;
      if (new_game) begin
        for (int i = 0; i < 9; i++) cells[i] = 0;
        mTurn = 0; mCount = 0; mWinner = 0; mOver = 0; mPending = 0;
      end else if (mPending) begin
        mPending = 0;
        if (lineOwner() != 0) begin
          mWinner = lineOwner();
          mOver = 1;
        end else if (mCount == 9) begin
          mWinner = 3;
          mOver = 1;
        end else begin
          mTurn = 1 - mTurn;
        end
      end else if (mOver) begin
        if (place) mErr = 1;
      end else if (place) begin
        if (cell_sel < 9 && cells[cell_sel] == 0) begin
          cells[cell_sel] = mTurn + 1;
          mCount++;
          mOk = 1;
          mPending = 1;
        end else begin
          mErr = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("board", 32'(board), 32'(packBoard()));
      checkOutput("turn", 32'(turn), 32'(mTurn));
      checkOutput("move_ok", 32'(move_ok), 32'(mOk));
      checkOutput("move_err", 32'(move_err), 32'(mErr));
      checkOutput("winner", 32'(winner), 32'(mWinner));
      checkOutput("game_over", 32'(game_over), 32'(mOver));
      checkOutput("ok_err_excl", 32'(move_ok & move_err), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [3:0] sel, input logic p, input logic ng);
    @(negedge clk);
    cell_sel = sel;
    place    = p;
    new_game = ng;
    @(negedge clk);
    place    = 1'b0;
    new_game = 1'b0;
  endtask

  task automatic playMove(input logic [3:0] sel);
    applyStimulus(sel, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    cell_sel = 4'd0;
    place    = 1'b0;
    new_game = 1'b0;
    repeat (2) @(negedge clk);
    checkEnable = 1'b1;
    checkOutput("lit_reset_board", 32'(board), 32'd0);
    checkOutput("lit_reset_over", 32'(game_over), 32'd0);
    reset = 1'b1;

    $display("[TB] out-of-range cursor and first move");
    applyStimulus(4'd12, 1'b1, 1'b0);
    checkOutput("lit_sel12_err", 32'(move_err), 32'd1);
    checkOutput("lit_sel12_board", 32'(board), 32'd0);
    applyStimulus(4'd4, 1'b1, 1'b0);
    checkOutput("lit_x4_ok", 32'(move_ok), 32'd1);
    checkOutput("lit_x4_board", 32'(board), 32'h00100);
    @(negedge clk);
    checkOutput("lit_x4_turn", 32'(turn), 32'd1);
    applyStimulus(4'd4, 1'b1, 1'b0);
    checkOutput("lit_o4_err", 32'(move_err), 32'd1);
    checkOutput("lit_o4_board", 32'(board), 32'h00100);
    checkOutput("lit_o4_turn", 32'(turn), 32'd1);

    $display("[TB] row win for X");
    applyStimulus(4'd0, 1'b0, 1'b1);
    playMove(4'd0); playMove(4'd3); playMove(4'd1); playMove(4'd4); playMove(4'd2);
    checkOutput("lit_row_winner", 32'(winner), 32'd1);
    checkOutput("lit_row_over", 32'(game_over), 32'd1);
    checkOutput("lit_row_board", 32'(board), 32'h00295);
    applyStimulus(4'd5, 1'b1, 1'b0);
    checkOutput("lit_over_err", 32'(move_err), 32'd1);
    checkOutput("lit_over_board", 32'(board), 32'h00295);

    $display("[TB] full-board draw");
    applyStimulus(4'd0, 1'b0, 1'b1);
    playMove(4'd0); playMove(4'd1); playMove(4'd2); playMove(4'd4); playMove(4'd3);
    playMove(4'd5); playMove(4'd7); playMove(4'd6); playMove(4'd8);
    checkOutput("lit_draw_winner", 32'(winner), 32'd3);
    checkOutput("lit_draw_over", 32'(game_over), 32'd1);
    checkOutput("lit_draw_board", 32'(board), 32'h16A59);
    applyStimulus(4'd0, 1'b0, 1'b1);
    checkOutput("lit_ng_board", 32'(board), 32'd0);
    checkOutput("lit_ng_turn", 32'(turn), 32'd0);
    checkOutput("lit_ng_winner", 32'(winner), 32'd0);

    $display("[TB] win on the ninth move");
    playMove(4'd0); playMove(4'd1); playMove(4'd2); playMove(4'd5); playMove(4'd3);
    playMove(4'd6); playMove(4'd4); playMove(4'd7); playMove(4'd8);
    checkOutput("lit_ninth_winner", 32'(winner), 32'd1);

    $display("[TB] new_game with place, then reset during evaluation");
    applyStimulus(4'd0, 1'b0, 1'b1);
    playMove(4'd0);
    applyStimulus(4'd1, 1'b1, 1'b1);
    checkOutput("lit_ngp_board", 32'(board), 32'd0);
    checkOutput("lit_ngp_ok", 32'(move_ok), 32'd0);
    checkOutput("lit_ngp_err", 32'(move_err), 32'd0);
    applyStimulus(4'd4, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("lit_async_board", 32'(board), 32'd0);
    checkOutput("lit_async_ok", 32'(move_ok), 32'd0);
    checkOutput("lit_async_turn", 32'(turn), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'd4, 1'b1, 1'b0);
    checkOutput("lit_after_reset_ok", 32'(move_ok), 32'd1);
    repeat (2) @(negedge clk);

    checkEnable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
